instr_loader: RTL and testbench



---
 rtl/instr_loader_pkg.sv | 15 +
 rtl/instr_loader_byte_packer.sv | 26 ++
 rtl/instr_loader.sv | 103 ++++++++++
 tb/tb_instr_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the boot-time instruction loader
package instr_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_ADDR_STEP = 4;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// rtl/instr_loader_byte_packer.sv - little-endian byte-to-word packer with clear and load enable
module loader_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  data,
    output logic [1:0]  idx,
    output logic [31:0] word
);

    // Clear wins over load so a restart never keeps a stale partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (clear) begin
            idx  <= 2'd0;
            word <= 32'd0;
        end else if (load) begin
            word[8*idx +: 8] <= data;
            idx              <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - packs a byte stream into instruction memory and releases the CPU once loaded
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_last_i,
    output logic        byte_ready_o,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_wdata_o,
    output logic        cpu_nrst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] word_count_o
);

    localparam logic [15:0] DEPTH_LIMIT = 16'(DEPTH_WORDS);
    localparam logic [1:0]  LAST_IDX    = 2'(BYTES_PER_WORD - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] word_count;
    logic        last_q;
    logic [1:0]  byte_idx;
    logic [31:0] word;
    logic        accept;
    logic        overflow;
    logic        restart;

    assign accept   = (state == RECV) && byte_valid_i;
    assign overflow = accept && (word_count == DEPTH_LIMIT);
    assign restart  = start_i && ((state == IDLE) || (state == DONE) || (state == ERR));

    loader_byte_packer u_packer (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (restart || (state == WRITE)),
        .load  (accept && !overflow),
        .data  (byte_data_i),
        .idx   (byte_idx),
        .word  (word)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start_i) state_nxt = RECV;
            end
            RECV: begin
                // Overflow is checked first: the byte that would start word DEPTH_WORDS is dropped.
                if (overflow) begin
                    state_nxt = ERR;
                end else if (accept && ((byte_idx == LAST_IDX) || byte_last_i)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = last_q ? DONE : RECV;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            word_count <= 16'd0;
            last_q     <= 1'b0;
        end else if (restart) begin
            word_count <= 16'd0;
            last_q     <= 1'b0;
        end else begin
            if (state == WRITE) word_count <= word_count + 16'd1;
            if (accept && !overflow) last_q <= byte_last_i;
        end
    end

    assign byte_ready_o = (state == RECV);
    assign im_we_o      = (state == WRITE);
    assign im_addr_o    = 32'(word_count) * 32'(WORD_ADDR_STEP);
    assign im_wdata_o   = (state == WRITE) ? word : 32'd0;
    assign cpu_nrst_o   = (state == DONE);
    assign busy_o       = (state == RECV) || (state == WRITE);
    assign done_o       = (state == DONE);
    assign err_o        = (state == ERR);
    assign word_count_o = word_count;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
module tb_instr_loader;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        bv = 1'b0;
    logic [7:0]  bd = 8'd0;
    logic        bl = 1'b0;
    logic        byte_ready, im_we, cpu_nrst, busy, done, err;
    logic [31:0] im_addr, im_wdata;
    logic [15:0] word_count;

    instr_loader #(.DEPTH_WORDS(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .byte_valid_i (bv),
        .byte_data_i  (bd),
        .byte_last_i  (bl),
        .byte_ready_o (byte_ready),
        .im_we_o      (im_we),
        .im_addr_o    (im_addr),
        .im_wdata_o   (im_wdata),
        .cpu_nrst_o   (cpu_nrst),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .word_count_o (word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string             name;
        int                n;
        logic [8:0][7:0]   b;
        int                nwr;
        logic [1:0][31:0]  d;
        logic              exp_err;
    } vec_t;

    vec_t        vecs[4];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always @(posedge clk) begin
        if (im_we) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_we"}, 32'(im_we), 32'd0);
        check({tag, "_addr"}, im_addr, 32'd0);
        check({tag, "_wdata"}, im_wdata, 32'd0);
        check({tag, "_nrst"}, 32'(cpu_nrst), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_count"}, 32'(word_count), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns just after the edge at which the byte was accepted.
    task automatic send_byte(input logic [7:0] d, input logic last, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bv = 1'b1;
        bd = d;
        bl = last;
        for (int i = 0; i < 20; i++) begin
            if (byte_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1;
        bv = 1'b0;
        bl = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_accept_timeout: got no ready want ready within 20 cycles");
        end
    endtask

    task automatic check_writes(input string tag, input int nwr, input logic [1:0][31:0] d);
        check({tag, "_nwr"}, 32'(wa.size()), 32'(nwr));
        for (int k = 0; k < nwr && k < wa.size(); k++) begin
            check({tag, "_addr"}, wa[k], 32'(4 * k));
            check({tag, "_data"}, wd[k], d[k]);
        end
    endtask

    initial begin
        vecs[0] = '{"two_word", 8, {8'h00, 8'h00, 8'h21, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00, 8'h13},
                    2, {32'h002100B3, 32'h00000013}, 1'b0};
        vecs[1] = '{"partial", 2, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hBB, 8'hAA},
                    1, {32'h0, 32'h0000BBAA}, 1'b0};
        vecs[2] = '{"overflow", 9, {8'h19, 8'h18, 8'h17, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11},
                    2, {32'h18171615, 32'h14131211}, 1'b1};
        vecs[3] = '{"five_byte", 5, {8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
                    2, {32'h00000005, 32'h04030201}, 1'b0};

        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            wa.delete();
            wd.delete();
            pulse_start();
            check({vecs[v].name, "_start_busy"}, 32'(busy), 32'd1);
            check({vecs[v].name, "_start_nrst"}, 32'(cpu_nrst), 32'd0);
            check({vecs[v].name, "_start_flags"}, {done, err}, 32'd0);
            check({vecs[v].name, "_start_count"}, 32'(word_count), 32'd0);
            for (int i = 0; i < vecs[v].n; i++)
                send_byte(vecs[v].b[i], !vecs[v].exp_err && (i == vecs[v].n - 1), 0);
            @(negedge clk);
            check({vecs[v].name, "_n1_we"}, 32'(im_we), 32'(!vecs[v].exp_err));
            check({vecs[v].name, "_n1_ready"}, 32'(byte_ready), 32'd0);
            check({vecs[v].name, "_n1_nrst"}, 32'(cpu_nrst), 32'd0);
            @(negedge clk);
            check({vecs[v].name, "_done"}, 32'(done), 32'(!vecs[v].exp_err));
            check({vecs[v].name, "_err"}, 32'(err), 32'(vecs[v].exp_err));
            check({vecs[v].name, "_nrst"}, 32'(cpu_nrst), 32'(!vecs[v].exp_err));
            check({vecs[v].name, "_busy"}, 32'(busy), 32'd0);
            check({vecs[v].name, "_count"}, 32'(word_count), 32'(vecs[v].nwr));
            repeat (3) @(negedge clk);
            check_writes(vecs[v].name, vecs[v].nwr, vecs[v].d);
        end

        // Stalls with an ignored start pulse mid-image must give the same memory image.
        wa.delete();
        wd.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(vecs[0].b[i], i == 7, int'($urandom_range(0, 4)));
            if (i == 1 || i == 3) pulse_start();
        end
        repeat (4) @(negedge clk);
        check("stall_done", 32'(done), 32'd1);
        check("stall_count", 32'(word_count), 32'd2);
        check_writes("stall", 2, vecs[0].d);

        // Asynchronous reset in mid-cycle from DONE.
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("async");
        @(negedge clk);
        rst = 1'b0;

        // Reset after two bytes discards the partial word; the next session restarts at 0.
        wa.delete();
        wd.delete();
        pulse_start();
        send_byte(8'h55, 1'b0, 0);
        send_byte(8'h66, 1'b0, 0);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midword_nwr", 32'(wa.size()), 32'd0);
        rst = 1'b0;
        pulse_start();
        send_byte(8'hA1, 1'b0, 0);
        send_byte(8'hA2, 1'b1, 0);
        repeat (3) @(negedge clk);
        check("reload_done", 32'(done), 32'd1);
        check_writes("reload", 1, {32'h0, 32'h0000A2A1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
